rs_frame_buffer: RTL and testbench

//  Ping-pong received-symbol store for the RS(255,239) decoder. It captures each incoming
//  n-symbol codeword while syndrome/BM/Chien/Forney process it, then replays it on

---
 rtl/rs_frame_buffer.sv | 163 ++++++++++++++++
 tb/tb_rs_frame_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_frame_buffer.sv
// rs_frame_buffer: two-bank ping-pong store of received RS symbols. One bank fills while
// the other is replayed, in arrival order, towards the error-correction stage.
module rs_frame_buffer #(
  parameter int n = 255,
  parameter int k = 239,
  parameter int t = 8,
  parameter int m = 8
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic [m-1:0] data_in,
  input  logic         data_valid_in,
  input  logic         frame_start_in,
  input  logic         replay_start,
  input  logic         err_clr,
  output logic [m-1:0] data_shifted,
  output logic         replay_active,
  output logic [1:0]   frames_pending,
  output logic         overflow_err,
  output logic         replay_err,
  output logic         short_frame_err
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);
  localparam logic [CW-1:0] NCNT = CW'(n);

  if (!((k < n) && (2 * t <= n - k))) begin : g_cfg_check
    $error("rs_frame_buffer: inconsistent n/k/t");
  end

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic {R_IDLE, R_PLAY} r_state_t;

  logic [m-1:0]  mem [0:1][0:n-1];
  w_state_t      w_state, w_next;
  r_state_t      r_state, r_next;
  logic [1:0]    full, full_next;
  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_cnt, wr_cnt_next, wr_idx;
  logic [CW-1:0] rd_cnt, rd_cnt_next, rd_idx;
  logic          wr_en, fill_done, ovf_set, short_set, wr_busy;
  logic          rd_issue, rd_free, rerr_set;
  logic          vld_p0, last_p0;
  logic [m-1:0]  rd_data_p0;

  // A bank released by the reader on this edge may be claimed by a new frame on the same edge.
  assign wr_busy = full[wr_bank] && !(rd_free && (rd_bank == wr_bank));
  assign frames_pending = {1'b0, full[0]} + {1'b0, full[1]};

  always_comb begin
    w_next      = w_state;
    wr_en       = 1'b0;
    wr_idx      = wr_cnt;
    wr_cnt_next = wr_cnt;
    fill_done   = 1'b0;
    ovf_set     = 1'b0;
    short_set   = 1'b0;
    if (data_valid_in && frame_start_in) begin
      if (wr_busy) begin
        ovf_set = 1'b1;
        w_next  = W_DROP;
      end else begin
        wr_en       = 1'b1;
        wr_idx      = '0;
        wr_cnt_next = CW'(1);
        short_set   = (w_state == W_FILL);
        w_next      = W_FILL;
      end
    end else if (data_valid_in && (w_state == W_FILL)) begin
      wr_en       = 1'b1;
      wr_cnt_next = wr_cnt + CW'(1);
      if (wr_cnt == LAST) begin
        fill_done   = 1'b1;
        wr_cnt_next = '0;
        w_next      = W_IDLE;
      end
    end
  end

  always_comb begin
    r_next      = r_state;
    rd_issue    = 1'b0;
    rd_idx      = rd_cnt;
    rd_cnt_next = rd_cnt;
    rd_free     = 1'b0;
    rerr_set    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (replay_start) begin
          if (full[rd_bank]) begin
            rd_issue    = 1'b1;
            rd_idx      = '0;
            rd_cnt_next = CW'(1);
            r_next      = R_PLAY;
          end else begin
            rerr_set = 1'b1;
          end
        end
      end
      R_PLAY: begin
        if (rd_cnt != NCNT) begin
          rd_issue    = 1'b1;
          rd_cnt_next = rd_cnt + CW'(1);
        end
        // Release the bank on the edge that presents its last symbol.
        if (last_p0) begin
          rd_free     = 1'b1;
          rd_cnt_next = '0;
          r_next      = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    full_next = full;
    if (fill_done) full_next[wr_bank] = 1'b1;
    if (rd_free)   full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      w_state         <= W_IDLE;
      r_state         <= R_IDLE;
      full            <= '0;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      vld_p0          <= 1'b0;
      last_p0         <= 1'b0;
      data_shifted    <= '0;
      replay_active   <= 1'b0;
      overflow_err    <= 1'b0;
      replay_err      <= 1'b0;
      short_frame_err <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      full    <= full_next;
      wr_cnt  <= wr_cnt_next;
      rd_cnt  <= rd_cnt_next;
      if (fill_done) wr_bank <= ~wr_bank;
      if (rd_free)   rd_bank <= ~rd_bank;
      // p0: bank read register -> output register
      vld_p0        <= rd_issue;
      last_p0       <= rd_issue && (rd_idx == LAST);
      data_shifted  <= vld_p0 ? rd_data_p0 : '0;
      replay_active <= vld_p0;
      overflow_err    <= ovf_set   | (overflow_err    & ~err_clr);
      replay_err      <= rerr_set  | (replay_err      & ~err_clr);
      short_frame_err <= short_set | (short_frame_err & ~err_clr);
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en)    mem[wr_bank][wr_idx] <= data_in;
    if (rd_issue) rd_data_p0 <= mem[rd_bank][rd_idx];
  end

endmodule

// File: tb/tb_rs_frame_buffer.sv
// Bench for rs_frame_buffer: scoreboard of replayed symbols plus a vector table for the
// replay-error flag and hand sequences for overflow, short frames, bank hand-off and reset.
module tb_rs_frame_buffer;

  localparam int N = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid_in = 1'b0;
  logic       frame_start_in = 1'b0;
  logic       replay_start = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_shifted;
  logic       replay_active;
  logic [1:0] frames_pending;
  logic       overflow_err, replay_err, short_frame_err;

  int n_checks = 0;
  int n_fail = 0;
  int m_pend = 0;
  logic [7:0] exp_q[$];

  rs_frame_buffer dut (
    .clk_in(clk), .rst_n(rst_n), .data_in(data_in), .data_valid_in(data_valid_in),
    .frame_start_in(frame_start_in), .replay_start(replay_start), .err_clr(err_clr),
    .data_shifted(data_shifted), .replay_active(replay_active),
    .frames_pending(frames_pending), .overflow_err(overflow_err),
    .replay_err(replay_err), .short_frame_err(short_frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sym(input int pat, input int i);
    logic [7:0] b;
    b = 8'(i);
    case (pat)
      0:       return b;
      1:       return ~b;
      default: return b ^ 8'h5A;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (replay_active) begin
        if (exp_q.size() == 0) chk("replay_unexpected", 32'd1, 32'd0);
        else chk("replay_data", {24'd0, data_shifted}, {24'd0, exp_q.pop_front()});
      end else begin
        chk("idle_data_zero", {24'd0, data_shifted}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the last symbol was sampled.
  task automatic write_frame(input int pat, input int len);
    if (len == N && m_pend < 2) begin
      for (int i = 0; i < N; i++) exp_q.push_back(sym(pat, i));
      m_pend++;
    end
    for (int i = 0; i < len; i++) begin
      data_valid_in  = 1'b1;
      frame_start_in = (i == 0);
      data_in        = sym(pat, i);
      @(negedge clk);
      if (pat == 2 && (i % 7) == 3) begin
        data_valid_in  = 1'b0;
        frame_start_in = 1'b0;
        data_in        = 8'hEE;
        @(negedge clk);
      end
    end
    data_valid_in  = 1'b0;
    frame_start_in = 1'b0;
    data_in        = '0;
  endtask

  task automatic replay(input bit expect_ok);
    int cnt;
    replay_start = 1'b1;
    if (expect_ok) m_pend--;
    @(negedge clk);
    replay_start = 1'b0;
    chk("replay_gap_cycle", {31'd0, replay_active}, 32'd0);
    @(negedge clk);
    chk("replay_first_active", {31'd0, replay_active}, {31'd0, expect_ok});
    cnt = replay_active ? 1 : 0;
    for (int i = 0; i < N + 4 && replay_active; i++) begin
      @(negedge clk);
      if (replay_active) cnt++;
    end
    chk("replay_len", cnt, expect_ok ? N : 0);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_overflow", {31'd0, overflow_err}, 32'd0);
    chk("clr_short", {31'd0, short_frame_err}, 32'd0);
    chk("clr_replay_err", {31'd0, replay_err}, 32'd0);
  endtask

  typedef struct {
    logic rs;
    logic clr;
    logic exp_rerr;
  } vec_t;

  vec_t tbl[6];
  int   cnt50;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0};

    #1;
    chk("reset_data", {24'd0, data_shifted}, 32'd0);
    chk("reset_active", {31'd0, replay_active}, 32'd0);
    chk("reset_pending", {30'd0, frames_pending}, 32'd0);
    chk("reset_flags", {29'd0, overflow_err, replay_err, short_frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Replay requests with nothing stored, against the sticky-flag table.
    for (int v = 0; v < 6; v++) begin
      replay_start = tbl[v].rs;
      err_clr      = tbl[v].clr;
      @(negedge clk);
      chk($sformatf("tbl%0d_replay_err", v), {31'd0, replay_err}, {31'd0, tbl[v].exp_rerr});
      chk($sformatf("tbl%0d_active", v), {31'd0, replay_active}, 32'd0);
      chk($sformatf("tbl%0d_pending", v), {30'd0, frames_pending}, 32'd0);
    end
    replay_start = 1'b0;
    err_clr      = 1'b0;

    // Valid symbols without a frame start are ignored while idle.
    data_valid_in = 1'b1;
    data_in       = 8'h33;
    repeat (5) @(negedge clk);
    data_valid_in = 1'b0;
    @(negedge clk);
    chk("idle_discard_pending", {30'd0, frames_pending}, 32'd0);

    // Single frame round trip.
    write_frame(0, N);
    chk("t1_pending_full", {30'd0, frames_pending}, 32'd1);
    replay(1'b1);
    chk("t1_pending_empty", {30'd0, frames_pending}, 32'd0);

    // Two frames, then a third whose start lands on the edge that frees the first bank.
    write_frame(0, N);
    write_frame(1, N);
    chk("t2_pending_two", {30'd0, frames_pending}, 32'd2);
    fork
      replay(1'b1);
      begin
        repeat (N) @(negedge clk);
        write_frame(2, N);
      end
    join
    chk("t2_handoff_no_overflow", {31'd0, overflow_err}, 32'd0);
    chk("t2_pending_after_handoff", {30'd0, frames_pending}, 32'd2);
    replay(1'b1);
    replay(1'b1);
    chk("t2_pending_empty", {30'd0, frames_pending}, 32'd0);
    chk("t2_no_flags", {29'd0, overflow_err, replay_err, short_frame_err}, 32'd0);

    // Overflow: third frame while both banks are full is dropped.
    write_frame(0, N);
    write_frame(1, N);
    write_frame(2, N);
    chk("t3_overflow_set", {31'd0, overflow_err}, 32'd1);
    chk("t3_pending_two", {30'd0, frames_pending}, 32'd2);
    replay(1'b1);
    replay(1'b1);
    chk("t3_overflow_sticky", {31'd0, overflow_err}, 32'd1);
    replay(1'b0);
    chk("t3_replay_err", {31'd0, replay_err}, 32'd1);
    clear_errs();

    // Short frame: restart at symbol 100.
    write_frame(2, 100);
    write_frame(1, N);
    chk("t5_short_set", {31'd0, short_frame_err}, 32'd1);
    chk("t5_pending_one", {30'd0, frames_pending}, 32'd1);
    replay(1'b1);
    clear_errs();

    // Reset in the middle of a replay.
    write_frame(0, N);
    replay_start = 1'b1;
    m_pend--;
    @(negedge clk);
    replay_start = 1'b0;
    cnt50 = 0;
    for (int i = 0; i < 60 && cnt50 < 50; i++) begin
      @(negedge clk);
      if (replay_active) cnt50++;
    end
    chk("t6_reached_symbol50", cnt50, 32'd50);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_data", {24'd0, data_shifted}, 32'd0);
    chk("t6_rst_active", {31'd0, replay_active}, 32'd0);
    chk("t6_rst_pending", {30'd0, frames_pending}, 32'd0);
    exp_q.delete();
    m_pend = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_pending", {30'd0, frames_pending}, 32'd0);
    write_frame(1, N);
    chk("t6_new_pending", {30'd0, frames_pending}, 32'd1);
    replay(1'b1);
    chk("t6_final_flags", {29'd0, overflow_err, replay_err, short_frame_err}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
